// File: rtl/acc_pkg.sv
// Shared constants for the ACC actuator arbiter: state codes, command width
// and default tuning values.
package acc_pkg;

    localparam int CMD_W = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_THROTTLE = 3'd1;
    localparam logic [2:0] ST_COAST    = 3'd2;
    localparam logic [2:0] ST_BRAKE    = 3'd3;
    localparam logic [2:0] ST_FAILSAFE = 3'd4;

    localparam int DEF_SLEW_STEP   = 4;
    localparam int DEF_DEADTIME    = 3;
    localparam int DEF_WDOG_CYCLES = 16;
    localparam int DEF_FS_BRAKE    = 32;

endpackage

// File: rtl/acc_slew_limiter.sv
// Next-value calculator for one actuator command; each direction either
// jumps straight to the target or moves at most STEP per cycle.
module acc_slew_limiter
    import acc_pkg::*;
#(
    parameter int STEP = DEF_SLEW_STEP
) (
    input  logic [CMD_W-1:0] target,
    input  logic [CMD_W-1:0] current,
    input  logic             rise_slewed,
    input  logic             fall_slewed,
    output logic [CMD_W-1:0] cmd_next
);

    localparam logic [CMD_W-1:0] STEP_C = CMD_W'(STEP);

    logic [CMD_W-1:0] diff;

    // Limits are decided on the distance to target, so current+STEP never wraps past 255.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; otherwise a latch is inferred.
        cmd_next = current;
        diff     = '0;
        if (target > current) begin
            diff     = target - current;
            cmd_next = (rise_slewed && diff > STEP_C) ? current + STEP_C : target;
        end else if (target < current) begin
            diff     = current - target;
            cmd_next = (fall_slewed && diff > STEP_C) ? current - STEP_C : target;
        end
    end

endmodule

// File: rtl/acc_actuator_arbiter.sv
// Throttle/brake arbiter: mutual exclusion with dead-time, comfort slew
// limiting and a request watchdog that forces a failsafe brake.
module acc_actuator_arbiter
    import acc_pkg::*;
#(
    parameter int SLEW_STEP   = DEF_SLEW_STEP,
    parameter int DEADTIME    = DEF_DEADTIME,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES,
    parameter int FS_BRAKE    = DEF_FS_BRAKE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       req_valid,
    input  logic [7:0] throttle_req,
    input  logic [7:0] brake_req,
    output logic [7:0] throttle_cmd,
    output logic [7:0] brake_cmd,
    output logic [2:0] state,
    output logic       fault
);

    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    localparam int DT_W = $clog2(DEADTIME + 1);

    logic [CMD_W-1:0] thr_tgt, brk_tgt, brk_goal;
    logic [CMD_W-1:0] thr_slew, brk_slew, thr_nx, brk_nx;
    logic [WD_W-1:0]  wdog;
    logic [DT_W-1:0]  dt_cnt, dt_nx;
    logic [2:0]       state_nx;
    logic             wdog_trip;

    // Trips on the edge where the idle count would reach WDOG_CYCLES.
    assign wdog_trip = enable && !req_valid && (wdog >= WD_W'(WDOG_CYCLES - 1))
                       && (state != ST_IDLE) && (state != ST_FAILSAFE);

    assign brk_goal = (state == ST_FAILSAFE || wdog_trip) ? CMD_W'(FS_BRAKE) : brk_tgt;

    acc_slew_limiter #(.STEP(SLEW_STEP)) u_thr_slew (
        .target      (thr_tgt),
        .current     (throttle_cmd),
        .rise_slewed (1'b1),
        .fall_slewed (1'b0),
        .cmd_next    (thr_slew)
    );

    acc_slew_limiter #(.STEP(SLEW_STEP)) u_brk_slew (
        .target      (brk_goal),
        .current     (brake_cmd),
        .rise_slewed (1'b0),
        .fall_slewed (1'b1),
        .cmd_next    (brk_slew)
    );

    always_comb begin
        state_nx = state;
        thr_nx   = throttle_cmd;
        brk_nx   = brake_cmd;
        dt_nx    = dt_cnt;
        if (!enable) begin
            state_nx = ST_IDLE;
            thr_nx   = '0;
            brk_nx   = '0;
            dt_nx    = '0;
        end else if (wdog_trip) begin
            state_nx = ST_FAILSAFE;
            thr_nx   = '0;
            brk_nx   = brk_slew;
            dt_nx    = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    thr_nx = '0;
                    brk_nx = '0;
                    if (brk_tgt != '0) begin
                        state_nx = ST_BRAKE;
                        brk_nx   = brk_slew;
                    end else if (thr_tgt != '0) begin
                        state_nx = ST_THROTTLE;
                        thr_nx   = thr_slew;
                    end
                end
                ST_THROTTLE: begin
                    brk_nx = '0;
                    if (brk_tgt != '0) begin
                        state_nx = ST_COAST;
                        thr_nx   = '0;
                        dt_nx    = DT_W'(DEADTIME - 1);
                    end else if (thr_tgt == '0 && throttle_cmd == '0) begin
                        state_nx = ST_IDLE;
                    end else begin
                        thr_nx = thr_slew;
                    end
                end
                ST_COAST: begin
                    // Dead-time always runs to completion; targets only matter at expiry.
                    thr_nx = '0;
                    brk_nx = '0;
                    if (dt_cnt != '0) begin
                        dt_nx = dt_cnt - 1'b1;
                    end else if (brk_tgt != '0) begin
                        state_nx = ST_BRAKE;
                        brk_nx   = brk_slew;
                    end else if (thr_tgt != '0) begin
                        state_nx = ST_THROTTLE;
                        thr_nx   = thr_slew;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_BRAKE: begin
                    thr_nx = '0;
                    if (brk_tgt == '0 && brake_cmd == '0) begin
                        if (thr_tgt != '0) begin
                            state_nx = ST_COAST;
                            dt_nx    = DT_W'(DEADTIME - 1);
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        brk_nx = brk_slew;
                    end
                end
                ST_FAILSAFE: begin
                    thr_nx = '0;
                    brk_nx = brk_slew;
                end
                default: begin
                    state_nx = ST_IDLE;
                    thr_nx   = '0;
                    brk_nx   = '0;
                    dt_nx    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            throttle_cmd <= '0;
            brake_cmd    <= '0;
            fault        <= 1'b0;
            thr_tgt      <= '0;
            brk_tgt      <= '0;
            wdog         <= '0;
            dt_cnt       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state        <= state_nx;
            throttle_cmd <= thr_nx;
            brake_cmd    <= brk_nx;
            fault        <= (state_nx == ST_FAILSAFE);
            dt_cnt       <= dt_nx;
            if (!enable) begin
                thr_tgt <= '0;
                brk_tgt <= '0;
                wdog    <= '0;
            end else if (req_valid) begin
                thr_tgt <= (brake_req != '0) ? '0 : throttle_req;
                brk_tgt <= brake_req;
                wdog    <= '0;
            end else if (wdog != WD_W'(WDOG_CYCLES)) begin
                wdog <= wdog + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_acc_actuator_arbiter.sv
// Scenario bench for acc_actuator_arbiter: each task queues the outputs it
// expects after every clock edge and the scoreboard drains them.
module tb_acc_actuator_arbiter;
    import acc_pkg::*;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] thr;
        logic [7:0] brk;
        logic       flt;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset, enable, req_valid;
    logic [7:0] throttle_req, brake_req;
    logic [7:0] throttle_cmd, brake_cmd;
    logic [2:0] state;
    logic       fault;

    int    checks = 0;
    int    errors = 0;
    obs_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    acc_actuator_arbiter #(
        .SLEW_STEP(4), .DEADTIME(3), .WDOG_CYCLES(16), .FS_BRAKE(32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .req_valid    (req_valid),
        .throttle_req (throttle_req),
        .brake_req    (brake_req),
        .throttle_cmd (throttle_cmd),
        .brake_cmd    (brake_cmd),
        .state        (state),
        .fault        (fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic req(input logic [7:0] thr, input logic [7:0] brk);
        req_valid    = 1'b1;
        throttle_req = thr;
        brake_req    = brk;
    endtask

    task automatic push(input logic [2:0] st, input int thr, input int brk,
                        input logic flt, input string tag);
        exp_q.push_back({st, 8'(thr), 8'(brk), flt});
        tag_q.push_back(tag);
    endtask

    // One expected entry per clock edge; finite queue bounds the loop.
    task automatic drain();
        obs_t  e, a;
        string t;
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {state, throttle_cmd, brake_cmd, fault};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got state=%0d thr=%0d brk=%0d fault=%0b, need state=%0d thr=%0d brk=%0d fault=%0b",
                         t, a.st, a.thr, a.brk, a.flt, e.st, e.thr, e.brk, e.flt);
            end
            checks++;
            if (throttle_cmd != 8'd0 && brake_cmd != 8'd0) begin
                errors++;
                $display("FAIL %s_exclusive: got thr=%0d brk=%0d, need one of them 0", t, throttle_cmd, brake_cmd);
            end
        end
    endtask

    task automatic go_idle();
        enable = 1'b0;
        push(ST_IDLE, 0, 0, 0, "enable_low");
        drain();
        enable = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({state, throttle_cmd, brake_cmd, fault} !== 20'd0) begin
            errors++;
            $display("FAIL %s: got state=%0d thr=%0d brk=%0d fault=%0b, need all 0",
                     tag, state, throttle_cmd, brake_cmd, fault);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; req_valid = 1'b0;
        throttle_req = '0; brake_req = '0;
        #3;
        check_zero("reset_values");
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        push(ST_IDLE, 0, 0, 0, "post_reset_idle");
        drain();
    endtask

    task automatic test_throttle_ramp();
        enable = 1'b1;
        req(20, 0);
        push(ST_IDLE, 0, 0, 0, "thr_capture");
        for (int k = 1; k <= 5; k++) push(ST_THROTTLE, 4 * k, 0, 0, "thr_ramp");
        push(ST_THROTTLE, 20, 0, 0, "thr_hold");
        drain();
    endtask

    task automatic test_throttle_to_brake();
        req(0, 30);
        push(ST_THROTTLE, 20, 0, 0, "t2b_capture");
        for (int k = 0; k < 3; k++) push(ST_COAST, 0, 0, 0, "t2b_coast");
        push(ST_BRAKE, 0, 30, 0, "t2b_brake_jump");
        push(ST_BRAKE, 0, 30, 0, "t2b_brake_hold");
        drain();
    endtask

    task automatic test_brake_release();
        req(10, 0);
        push(ST_BRAKE, 0, 30, 0, "b2t_capture");
        for (int k = 1; k <= 8; k++) push(ST_BRAKE, 0, (30 - 4 * k < 0) ? 0 : 30 - 4 * k, 0, "b2t_release");
        for (int k = 0; k < 3; k++) push(ST_COAST, 0, 0, 0, "b2t_coast");
        push(ST_THROTTLE, 4, 0, 0, "b2t_thr");
        push(ST_THROTTLE, 8, 0, 0, "b2t_thr");
        push(ST_THROTTLE, 10, 0, 0, "b2t_thr_final");
        drain();
    endtask

    task automatic test_brake_priority();
        go_idle();
        req(50, 10);
        push(ST_IDLE, 0, 0, 0, "prio_capture");
        push(ST_BRAKE, 0, 10, 0, "prio_brake");
        push(ST_BRAKE, 0, 10, 0, "prio_hold");
        drain();
    endtask

    task automatic test_enable_dominates();
        enable = 1'b0;
        req(40, 0);
        push(ST_IDLE, 0, 0, 0, "en_low_with_req");
        drain();
        enable = 1'b1;
        push(ST_IDLE, 0, 0, 0, "en_req_dropped");
        push(ST_IDLE, 0, 0, 0, "en_req_dropped");
        drain();
    endtask

    task automatic test_full_scale();
        int v;
        go_idle();
        req(255, 0);
        push(ST_IDLE, 0, 0, 0, "fs255_capture");
        drain();
        for (int k = 1; k <= 66; k++) begin
            if (k % 8 == 0) req(255, 0);
            v = (4 * k > 255) ? 255 : 4 * k;
            push(ST_THROTTLE, v, 0, 0, "fs255_ramp");
            drain();
        end
    endtask

    task automatic test_watchdog();
        go_idle();
        req(20, 0);
        push(ST_IDLE, 0, 0, 0, "wd_capture");
        for (int k = 1; k <= 15; k++) push(ST_THROTTLE, (4 * k > 20) ? 20 : 4 * k, 0, 0, "wd_running");
        push(ST_FAILSAFE, 0, 32, 1, "wd_trip");
        push(ST_FAILSAFE, 0, 32, 1, "wd_hold");
        drain();
        req(20, 0);
        push(ST_FAILSAFE, 0, 32, 1, "wd_req_ignored");
        push(ST_FAILSAFE, 0, 32, 1, "wd_req_ignored");
        drain();
        enable = 1'b0;
        push(ST_IDLE, 0, 0, 0, "wd_exit");
        drain();
        enable = 1'b1;
        push(ST_IDLE, 0, 0, 0, "wd_after_exit");
        drain();
    endtask

    task automatic test_watchdog_brake_slew();
        int v;
        go_idle();
        req(0, 100);
        push(ST_IDLE, 0, 0, 0, "wdb_capture");
        for (int k = 1; k <= 15; k++) push(ST_BRAKE, 0, 100, 0, "wdb_brake");
        for (int k = 16; k <= 34; k++) begin
            v = 100 - 4 * (k - 15);
            push(ST_FAILSAFE, 0, (v < 32) ? 32 : v, 1, "wdb_slew_down");
        end
        drain();
    endtask

    task automatic test_async_reset();
        go_idle();
        req(20, 0);
        push(ST_IDLE, 0, 0, 0, "ar_capture");
        push(ST_THROTTLE, 4, 0, 0, "ar_ramp");
        push(ST_THROTTLE, 8, 0, 0, "ar_ramp");
        drain();
        #2 reset = 1'b1;
        #1 check_zero("async_reset_mid_ramp");
        #2 reset = 1'b0;
        push(ST_IDLE, 0, 0, 0, "ar_targets_cleared");
        push(ST_IDLE, 0, 0, 0, "ar_targets_cleared");
        drain();
        req(20, 0);
        push(ST_IDLE, 0, 0, 0, "ar2_capture");
        push(ST_THROTTLE, 4, 0, 0, "ar2_ramp");
        drain();
        req(0, 30);
        push(ST_THROTTLE, 8, 0, 0, "ar2_brake_capture");
        push(ST_COAST, 0, 0, 0, "ar2_coast");
        drain();
        #2 reset = 1'b1;
        #1 check_zero("async_reset_mid_coast");
        #2 reset = 1'b0;
        push(ST_IDLE, 0, 0, 0, "ar2_after_reset");
        push(ST_IDLE, 0, 0, 0, "ar2_after_reset");
        drain();
    endtask

    initial begin
        test_reset();
        test_throttle_ramp();
        test_throttle_to_brake();
        test_brake_release();
        test_brake_priority();
        test_enable_dominates();
        test_full_scale();
        test_watchdog();
        test_watchdog_brake_slew();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
